// File: rtl/sum_accumulator_pkg.sv
// Shared constants for the checksum stage: FSM encoding, block lengths, lane count.
package sum_accumulator_pkg;

    localparam int NUM_LANES  = 8;
    localparam int LANE_SEL_W = 3;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Block lengths selected by the DLEN code
    localparam logic [6:0] LEN_8  = 7'd8;
    localparam logic [6:0] LEN_16 = 7'd16;
    localparam logic [6:0] LEN_32 = 7'd32;
    localparam logic [6:0] LEN_64 = 7'd64;

    function automatic logic [6:0] len_from_code(input logic [1:0] code);
        case (code)
            2'b00:   return LEN_8;
            2'b01:   return LEN_16;
            2'b10:   return LEN_32;
            default: return LEN_64;
        endcase
    endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Bus between the AHB master and the checksum stage: block control, data handshake, results.
interface sum_accumulator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  START;
    logic [1:0]            DLEN;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  DATA_VALID;
    logic                  DATA_READY;
    logic                  ABORT;
    logic                  SUM_ACK;
    logic [DATA_WIDTH-1:0] SUM1, SUM2, SUM3, SUM4, SUM5, SUM6, SUM7, SUM8;
    logic                  isSumReady;
    logic                  BUSY;
    logic                  ERR;

    // AHB master side
    modport master (
        output START, DLEN, DATA_IN, DATA_VALID, ABORT, SUM_ACK,
        input  DATA_READY, SUM1, SUM2, SUM3, SUM4, SUM5, SUM6, SUM7, SUM8,
        input  isSumReady, BUSY, ERR
    );

    // Accumulator side
    modport slave (
        input  START, DLEN, DATA_IN, DATA_VALID, ABORT, SUM_ACK,
        output DATA_READY, SUM1, SUM2, SUM3, SUM4, SUM5, SUM6, SUM7, SUM8,
        output isSumReady, BUSY, ERR
    );
endinterface

// File: rtl/sum_accumulator_lane_bank.sv
// Eight interleaved lane sum registers; one selected lane accumulates per enabled cycle.
module sum_lane_bank
    import sum_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  add_en,
    input  logic [LANE_SEL_W-1:0]                 sel,
    input  logic [DATA_WIDTH-1:0]                 data,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  sums
);

    // Clear wins over add so a new block always starts from zero; carries are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sums <= '0;
        end else if (clr) begin
            sums <= '0;
        end else if (add_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (sel == LANE_SEL_W'(i)) begin
                    sums[i] <= sums[i] + data;
                end
            end
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Checksum stage: accumulates a block of read beats into eight interleaved lane sums
// and holds them for the master until acknowledged.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 7
) (
    input  logic              HCLK,
    input  logic              RESET,
    sum_accumulator_if.slave  bus
);

    logic [1:0]                           state;
    logic [CNT_WIDTH-1:0]                 cnt;
    logic [CNT_WIDTH-1:0]                 len;
    logic                                 busy;
    logic                                 ready;
    logic                                 err;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] sums;

    logic start_blk;
    logic beat;
    logic last_beat;

    // START is only honoured outside a block; ABORT discards a same-cycle beat.
    assign start_blk = bus.START && (state != ST_ACCUM);
    assign beat      = (state == ST_ACCUM) && bus.DATA_VALID && !bus.ABORT;
    assign last_beat = beat && (cnt == len - CNT_WIDTH'(1));

    // Block sequencing, beat counter and registered status flags.
    always_ff @(posedge HCLK) begin
        if (!RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
            len   <= CNT_WIDTH'(LEN_8);
            busy  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // START from DONE doubles as the acknowledge of the previous result
                    if (start_blk) begin
                        len   <= CNT_WIDTH'(len_from_code(bus.DLEN));
                        cnt   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                        state <= ST_ACCUM;
                    end else if (state == ST_DONE && bus.SUM_ACK) begin
                        ready <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (bus.ABORT) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (beat) begin
                        cnt <= cnt + CNT_WIDTH'(1);
                        if (last_beat) begin
                            busy  <= 1'b0;
                            ready <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sum_lane_bank #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk    (HCLK),
        .rst_n  (RESET),
        .clr    (start_blk),
        .add_en (beat),
        .sel    (cnt[LANE_SEL_W-1:0]),
        .data   (bus.DATA_IN),
        .sums   (sums)
    );

    assign bus.DATA_READY = (state == ST_ACCUM);
    assign bus.BUSY       = busy;
    assign bus.isSumReady = ready;
    assign bus.ERR        = err;
    assign bus.SUM1       = sums[0];
    assign bus.SUM2       = sums[1];
    assign bus.SUM3       = sums[2];
    assign bus.SUM4       = sums[3];
    assign bus.SUM5       = sums[4];
    assign bus.SUM6       = sums[5];
    assign bus.SUM7       = sums[6];
    assign bus.SUM8       = sums[7];

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: block-level model compared every cycle plus literal checks.
module tb_sum_accumulator;

    logic HCLK;
    logic RESET;
    int   n_checks;
    int   n_fail;
    bit   chk_en;

    sum_accumulator_if #(.DATA_WIDTH(16)) bus ();

    sum_accumulator #(.DATA_WIDTH(16), .CNT_WIDTH(7)) dut (
        .HCLK  (HCLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- block-level model ----------------
    // A block is a list of accepted words; lane n sums every word whose index mod 8 is n.
    bit          m_active;
    bit          m_done;
    bit          m_err;
    int          m_len;
    logic [15:0] m_words[$];

    always @(posedge HCLK) begin
        if (!RESET) begin
            m_active = 0; m_done = 0; m_err = 0; m_len = 8;
            m_words.delete();
        end else if (m_active) begin
            if (bus.ABORT) begin
                m_active = 0; m_err = 1;
            end else if (bus.DATA_VALID) begin
                m_words.push_back(bus.DATA_IN);
                if (m_words.size() == m_len) begin
                    m_active = 0; m_done = 1;
                end
            end
        end else if (bus.START) begin
            m_len = 8 << int'(bus.DLEN);
            m_words.delete();
            m_err = 0; m_active = 1; m_done = 0;
        end else if (bus.SUM_ACK) begin
            m_done = 0;
        end
    end

    function automatic logic [15:0] exp_sum(input int lane);
        logic [15:0] s;
        s = '0;
        foreach (m_words[i]) if (i % 8 == lane) s = s + m_words[i];
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_sum(input int lane);
        case (lane)
            0: return bus.SUM1; 1: return bus.SUM2; 2: return bus.SUM3; 3: return bus.SUM4;
            4: return bus.SUM5; 5: return bus.SUM6; 6: return bus.SUM7; default: return bus.SUM8;
        endcase
    endfunction

    // Compare process: every cycle once reset has been applied.
    always @(negedge HCLK) begin
        if (chk_en) begin
            for (int l = 0; l < 8; l++) check($sformatf("model_sum%0d", l + 1), 32'(dut_sum(l)), 32'(exp_sum(l)));
            check("model_ready", 32'(bus.isSumReady), 32'(m_done));
            check("model_busy",  32'(bus.BUSY),       32'(m_active));
            check("model_err",   32'(bus.ERR),        32'(m_err));
            check("model_drdy",  32'(bus.DATA_READY), 32'(m_active));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic start_blk(input logic [1:0] code);
        bus.START = 1'b1; bus.DLEN = code;
        tick();
        bus.START = 1'b0; bus.DLEN = 2'b11;  // later DLEN changes must not matter
    endtask

    task automatic send(input logic [15:0] w);
        bus.DATA_VALID = 1'b1; bus.DATA_IN = w;
        tick();
        bus.DATA_VALID = 1'b0; bus.DATA_IN = 16'hDEAD;
    endtask

    initial begin
        int cyc;
        n_checks = 0; n_fail = 0; chk_en = 0;
        RESET = 1'b0;
        bus.START = 0; bus.DLEN = 0; bus.DATA_IN = 0; bus.DATA_VALID = 0;
        bus.ABORT = 0; bus.SUM_ACK = 0;
        tick();
        chk_en = 1;
        tick();
        check("reset_sum1", 32'(bus.SUM1), 32'h0);
        check("reset_drdy", 32'(bus.DATA_READY), 32'h0);
        RESET = 1'b1;
        tick();

        // 1: eight words, continuous valid
        start_blk(2'b00);
        for (int i = 1; i <= 8; i++) begin
            check("s1_not_ready", 32'(bus.isSumReady), 32'h0);
            send(16'(i));
        end
        check("s1_ready", 32'(bus.isSumReady), 32'h1);
        check("s1_drdy_done", 32'(bus.DATA_READY), 32'h0);
        for (int l = 0; l < 8; l++) check($sformatf("s1_sum%0d", l + 1), 32'(dut_sum(l)), 32'(l + 1));
        bus.SUM_ACK = 1; tick(); bus.SUM_ACK = 0;

        // 2: sixteen words; stray START and SUM_ACK mid-block are ignored
        start_blk(2'b01);
        for (int i = 1; i <= 16; i++) begin
            if (i == 4) begin bus.START = 1; bus.DLEN = 2'b00; end
            if (i == 6) bus.SUM_ACK = 1;
            send(16'(i));
            bus.START = 0; bus.SUM_ACK = 0;
        end
        for (int l = 0; l < 8; l++) check($sformatf("s2_sum%0d", l + 1), 32'(dut_sum(l)), 32'(10 + 2 * l));
        tick();
        check("s2_hold_ready", 32'(bus.isSumReady), 32'h1);
        bus.SUM_ACK = 1; tick(); bus.SUM_ACK = 0;
        check("s2_ack_ready", 32'(bus.isSumReady), 32'h0);
        check("s2_ack_drdy", 32'(bus.DATA_READY), 32'h0);
        check("s2_ack_hold", 32'(bus.SUM1), 32'd10);

        // 3: wrap-around; second block started straight from DONE
        start_blk(2'b00);
        send(16'hFFFF);
        for (int i = 1; i < 8; i++) send(16'h0000);
        check("s3a_sum1", 32'(bus.SUM1), 32'hFFFF);
        start_blk(2'b01);
        check("s3_implicit_ack", 32'(bus.isSumReady), 32'h0);
        check("s3_cleared", 32'(bus.SUM1), 32'h0);
        send(16'hFFFF);
        for (int i = 1; i < 8; i++) send(16'h0000);
        send(16'h0002);
        for (int i = 9; i < 16; i++) send(16'h0000);
        check("s3_wrap_sum1", 32'(bus.SUM1), 32'h0001);
        bus.SUM_ACK = 1; tick(); bus.SUM_ACK = 0;

        // 4: valid gaps stretch the block by the stall count
        start_blk(2'b00);
        cyc = 1;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i)); cyc++;
            if (i < 8) begin tick(); cyc++; end
        end
        check("s4_ready", 32'(bus.isSumReady), 32'h1);
        check("s4_cycles", 32'(cyc), 32'd16);
        for (int l = 0; l < 8; l++) check($sformatf("s4_sum%0d", l + 1), 32'(dut_sum(l)), 32'(l + 1));

        // 5: abort after five beats, with a beat and START in the same cycle
        start_blk(2'b01);
        for (int i = 1; i <= 5; i++) send(16'(i * 3));
        bus.ABORT = 1; bus.START = 1; bus.DATA_VALID = 1; bus.DATA_IN = 16'h0100;
        tick();
        bus.ABORT = 0; bus.START = 0; bus.DATA_VALID = 0;
        check("s5_err", 32'(bus.ERR), 32'h1);
        check("s5_ready", 32'(bus.isSumReady), 32'h0);
        check("s5_busy", 32'(bus.BUSY), 32'h0);
        check("s5_discard", 32'(bus.SUM6), 32'h0);
        tick();
        check("s5_idle", 32'(bus.DATA_READY), 32'h0);
        start_blk(2'b00);
        check("s5_err_clr", 32'(bus.ERR), 32'h0);
        check("s5_sum_clr", 32'(bus.SUM1), 32'h0);
        for (int i = 1; i <= 8; i++) send(16'h0010);
        bus.SUM_ACK = 1; tick(); bus.SUM_ACK = 0;

        // 6: reset mid-block, START in the reset cycle ignored
        start_blk(2'b01);
        for (int i = 1; i <= 3; i++) send(16'h0050);
        RESET = 0; bus.START = 1; bus.DLEN = 2'b00; bus.DATA_VALID = 1; bus.DATA_IN = 16'h0007;
        tick();
        RESET = 1; bus.START = 0; bus.DATA_VALID = 0;
        check("s6_sum1", 32'(bus.SUM1), 32'h0);
        check("s6_sum3", 32'(bus.SUM3), 32'h0);
        check("s6_busy", 32'(bus.BUSY), 32'h0);
        check("s6_ready", 32'(bus.isSumReady), 32'h0);
        tick();
        check("s6_idle", 32'(bus.DATA_READY), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Checksum stage sitting beside AHB_MASTER. It consumes the data words the master reads over AHB (HRDATA beats) and accumulates them into eight interleaved lane sums. It then presents SUM1..SUM8 with isSumReady, which the master writes back to the CRC address. One block-length transaction per START; results are held until acknowledged.

Parameters:
DATA_WIDTH, 16, width of data words and of each lane sum.
CNT_WIDTH, 7, width of the beat counter (must hold 64).

Ports:
HCLK  in  1  clock, rising edge.
RESET  in  1  synchronous active-low reset.
START  in  1  one-cycle pulse; begin a block and latch DLEN.
DLEN  in  2  block length code: 00=8, 01=16, 10=32, 11=64 words.
DATA_IN  in  DATA_WIDTH  data word from the master.
DATA_VALID  in  1  DATA_IN is valid this cycle.
DATA_READY  out  1  engine accepts a word this cycle.
ABORT  in  1  error (e.g. HRESP) reported by the master; cancel the block.
SUM_ACK  in  1  master has consumed the sums; release them.
SUM1..SUM8  out  DATA_WIDTH each  lane sums.
isSumReady  out  1  sums are final and stable.
BUSY  out  1  block in progress.
ERR  out  1  last block was aborted; sticky until next START.

Behaviour:
- Reset: when RESET=0 at a clock edge, state=IDLE, all SUMn=0, isSumReady=0, DATA_READY=0, BUSY=0, ERR=0, counter=0, latched length=8. This overrides every other input, including mid-block.
- States: IDLE, ACCUM, DONE.
- IDLE: DATA_READY=0. On START:
  - latch len from DLEN;
  - clear SUM1..8, counter, ERR;
  - next state=ACCUM.
- ACCUM: DATA_READY=1 and BUSY=1.
  - Beat = DATA_VALID & DATA_READY.
  - On a beat with counter k: SUM((k mod 8)+1) <= SUM((k mod 8)+1) + DATA_IN, modulo 2^DATA_WIDTH (carry discarded). Counter increments.
  - DATA_VALID low causes a stall: sums and counter hold.
  - When the beat with k = len-1 is accepted, next state=DONE.
  - isSumReady=1 from the following cycle, one cycle after the last beat.
- DONE:
  - DATA_READY=0, BUSY=0, isSumReady=1; SUMn held stable.
  - On SUM_ACK: isSumReady=0, next state=IDLE. Sums keep their values until the next START.
  - On START without SUM_ACK: treated as an implicit ack, and a new block begins exactly as from IDLE.
- ABORT:
  - In ACCUM: next state=IDLE, ERR=1, isSumReady stays 0, and a beat presented in the same cycle is discarded.
  - In IDLE or DONE: ignored.
- START while in ACCUM is ignored. DLEN changes outside a START cycle are ignored.
- ABORT together with START in ACCUM: ABORT wins.
- SUM_ACK outside DONE is ignored.
- All outputs are registered except DATA_READY, which is decoded from state.

Decomposition:
- Shared package:
  - state encoding (IDLE/ACCUM/DONE);
  - DLEN-to-length constants (8/16/32/64);
  - lane count constant 8.
- One natural sub-module: sum_lane_bank. It holds the 8 DATA_WIDTH registers with clear, lane-select (3-bit) and add-enable inputs. The FSM and counter stay in the top level.

Test Plan:
1. Reset, START with DLEN=00, words 1..8 streamed with continuous valid -> SUM1..SUM8=1..8. isSumReady rises 1 cycle after the 8th beat; DATA_READY=0 in DONE.
2. DLEN=01, words 1..16 -> SUM1=10, SUM2=12, ..., SUM8=24. SUM_ACK then drops isSumReady next cycle and returns to IDLE.
3. Wrap-around: DLEN=00, word0=0xFFFF, word8 absent (len 8), word0 second block 0xFFFF+0x0002 via DLEN=01 lane1 -> SUM1=0x0001.
4. Valid gaps: DLEN=00, DATA_VALID toggled 1/0 -> same sums as scenario 1, isSumReady delayed by the stall count.
5. ABORT after 5 beats -> IDLE, ERR=1, isSumReady=0. A following START clears ERR and the sums.
6. RESET=0 asserted mid-ACCUM (beat 3 of 16) -> next cycle all SUMn=0, BUSY=0, isSumReady=0. START in the same cycle as RESET=0 is ignored.
